alu_muldiv: RTL and testbench

- Parametrised successor to the pipeline EX-stage ALU.
- Keeps the single-cycle combinational operations and the branch-condition flag.
- Replaces the combinational multiply with an iterative multiply/divide unit that holds HI/LO registers. It supports signed and unsigned MUL/DIV plus MFHI/MFLO.
- Sits in EX. While a multi-cycle operation is running, it stalls IF/ID/EX through `stall`.

---
 rtl/alu_muldiv_pkg.sv | 46 ++++
 rtl/alu_muldiv_if.sv | 30 +++
 rtl/alu_muldiv_iter.sv | 179 +++++++++++++++++
 rtl/alu_muldiv.sv | 102 ++++++++++
 tb/tb_alu_muldiv.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_muldiv_pkg.sv
// alu_pkg: shared encodings for the EX-stage ALU and its iterative
// multiply/divide unit (operation selects, branch opcodes, FSM states).
package alu_pkg;

    // ALUCtl operation selects
    localparam logic [4:0] ALU_AND  = 5'b00000;
    localparam logic [4:0] ALU_OR   = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00010;
    localparam logic [4:0] ALU_SUB  = 5'b00110;
    localparam logic [4:0] ALU_SLT  = 5'b00111;
    localparam logic [4:0] ALU_NOR  = 5'b01100;
    localparam logic [4:0] ALU_XOR  = 5'b01101;
    localparam logic [4:0] ALU_SLL  = 5'b10000;
    localparam logic [4:0] ALU_SRL  = 5'b11000;
    localparam logic [4:0] ALU_SRA  = 5'b11001;
    localparam logic [4:0] ALU_MFLO = 5'b11100;
    localparam logic [4:0] ALU_MFHI = 5'b11101;
    localparam logic [4:0] ALU_DIV  = 5'b11110;
    localparam logic [4:0] ALU_MUL  = 5'b11111;

    // Branch opcodes that drive the zero flag
    localparam logic [5:0] OP_BLTZ = 6'b000001;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BLEZ = 6'b000110;
    localparam logic [5:0] OP_BGTZ = 6'b000111;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdState_t;

    // True for the operations that start the iterative unit
    function automatic logic isMulDiv(input logic [4:0] ctl);
        return (ctl == ALU_MUL) || (ctl == ALU_DIV);
    endfunction

    // True for every operation that depends on the iterative unit or HI/LO
    function automatic logic usesHiLo(input logic [4:0] ctl);
        return (ctl == ALU_MUL) || (ctl == ALU_DIV) ||
               (ctl == ALU_MFHI) || (ctl == ALU_MFLO);
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: EX-stage operand/result bundle between the pipeline
// (master) and the ALU with its multiply/divide unit (slave).
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic             flush;
    logic [5:0]       OpCode;
    logic [4:0]       ALUCtl;
    logic             Sign;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             md_busy;
    logic             md_done;
    logic             stall;

    modport master (
        output op_valid, flush, OpCode, ALUCtl, Sign, in1, in2,
        input  out, zero, hi, lo, md_busy, md_done, stall
    );

    modport slave (
        input  op_valid, flush, OpCode, ALUCtl, Sign, in1, in2,
        output out, zero, hi, lo, md_busy, md_done, stall
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// muldiv_iter: iterative signed/unsigned multiply (shift-add) and
// restoring divide, one bit per cycle, with a final sign-fix cycle that
// loads the HI/LO registers.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic             i_isDiv,
    input  logic             i_sign,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done,
    output mdState_t         o_state
);

    mdState_t           r_state;
    mdState_t           w_nextState;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_opA;
    logic               r_isDiv;
    logic               r_negRes;
    logic               r_negRem;
    logic               r_divZero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_lastIter;
    logic               w_aNeg;
    logic               w_bNeg;
    logic [WIDTH-1:0]   w_aMag;
    logic [WIDTH-1:0]   w_bMag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    logic [2*WIDTH-1:0] w_stepProd;
    logic [2*WIDTH-1:0] w_negProd;
    logic [WIDTH-1:0]   w_fixHi;
    logic [WIDTH-1:0]   w_fixLo;

    assign w_accept   = i_start && !i_flush && (r_state == ST_IDLE);
    assign w_lastIter = (r_count == CW'(WIDTH - 1));

    // Operand magnitudes; the most negative value maps onto its own bit
    // pattern, which is the correct unsigned magnitude.
    assign w_aNeg = i_sign && i_a[WIDTH-1];
    assign w_bNeg = i_sign && i_b[WIDTH-1];
    assign w_aMag = w_aNeg ? (~i_a + 1'b1) : i_a;
    assign w_bMag = w_bNeg ? (~i_b + 1'b1) : i_b;

    // Multiply step adds into the upper half; divide step shifts the next
    // dividend bit into the partial remainder. Both share r_prod.
    assign w_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_divisor};
    assign w_shift = r_prod[2*WIDTH-1:WIDTH-1];
    assign w_ge    = (w_shift >= {1'b0, r_divisor});
    assign w_sub   = w_shift[WIDTH-1:0] - r_divisor;

    // One iteration of whichever operation is running
    always_comb begin
        w_stepProd = r_prod;
        if (r_isDiv) begin
            if (w_ge) begin
                w_stepProd = {w_sub, r_prod[WIDTH-2:0], 1'b1};
            end else begin
                w_stepProd = {w_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0};
            end
        end else if (r_prod[0]) begin
            w_stepProd = {w_sum, r_prod[WIDTH-1:1]};
        end else begin
            w_stepProd = {1'b0, r_prod[2*WIDTH-1:1]};
        end
    end

    assign w_negProd = ~r_prod + 1'b1;

    // Sign correction applied during FIX; divide-by-zero returns all ones
    // and the original dividend instead of the raw restoring result.
    always_comb begin
        w_fixHi = r_prod[2*WIDTH-1:WIDTH];
        w_fixLo = r_prod[WIDTH-1:0];
        if (!r_isDiv) begin
            if (r_negRes) begin
                w_fixHi = w_negProd[2*WIDTH-1:WIDTH];
                w_fixLo = w_negProd[WIDTH-1:0];
            end
        end else if (r_divZero) begin
            w_fixHi = r_opA;
            w_fixLo = '1;
        end else begin
            if (r_negRes) w_fixLo = ~r_prod[WIDTH-1:0] + 1'b1;
            if (r_negRem) w_fixHi = ~r_prod[2*WIDTH-1:WIDTH] + 1'b1;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_nextState;
    end

    // Next state plus busy/done; flush aborts RUN or FIX without a done pulse
    always_comb begin
        w_nextState = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_nextState = ST_RUN;
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (i_flush)         w_nextState = ST_IDLE;
                else if (w_lastIter) w_nextState = ST_FIX;
            end
            ST_FIX: begin
                o_busy      = 1'b1;
                o_done      = !i_flush;
                w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Operand capture at acceptance and the per-cycle iteration datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_prod    <= '0;
            r_divisor <= '0;
            r_opA     <= '0;
            r_isDiv   <= 1'b0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
        end else if (w_accept) begin
            r_count   <= '0;
            r_prod    <= {{WIDTH{1'b0}}, w_aMag};
            r_divisor <= w_bMag;
            r_opA     <= i_a;
            r_isDiv   <= i_isDiv;
            r_negRes  <= w_aNeg ^ w_bNeg;
            r_negRem  <= w_aNeg;
            r_divZero <= (i_b == '0);
        end else if (r_state == ST_RUN) begin
            r_count <= r_count + 1'b1;
            r_prod  <= w_stepProd;
        end else begin
            r_count <= '0;
        end
    end

    // HI/LO load at the edge that closes an unflushed FIX cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if ((r_state == ST_FIX) && !i_flush) begin
            r_hi <= w_fixHi;
            r_lo <= w_fixLo;
        end
    end

    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_state = r_state;

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage ALU with combinational single-cycle operations,
// branch-condition flag, and an iterative MUL/DIV unit with HI/LO that
// holds the pipeline while it works.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int CW    = 6
) (
    input  logic         clk,
    input  logic         reset,
    alu_muldiv_if.slave  bus
);

    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_aluOut;
    logic [SHW-1:0]   w_shamt;
    logic             w_lt;
    logic             w_zero;
    logic             w_start;
    logic             w_busy;
    logic             w_done;
    mdState_t         w_state;

    assign w_shamt = bus.in1[SHW-1:0];

    // Less-than for SLT, signed or unsigned by Sign
    always_comb begin
        w_lt = 1'b0;
        if (bus.Sign) w_lt = ($signed(bus.in1) < $signed(bus.in2));
        else          w_lt = (bus.in1 < bus.in2);
    end

    // Single-cycle result; MUL/DIV show the current LO while they start
    always_comb begin
        w_aluOut = '0;
        case (bus.ALUCtl)
            ALU_AND:  w_aluOut = bus.in1 & bus.in2;
            ALU_OR:   w_aluOut = bus.in1 | bus.in2;
            ALU_ADD:  w_aluOut = bus.in1 + bus.in2;
            ALU_SUB:  w_aluOut = bus.in1 - bus.in2;
            ALU_SLT:  w_aluOut = {{(WIDTH-1){1'b0}}, w_lt};
            ALU_NOR:  w_aluOut = ~(bus.in1 | bus.in2);
            ALU_XOR:  w_aluOut = bus.in1 ^ bus.in2;
            ALU_SLL:  w_aluOut = bus.in2 << w_shamt;
            ALU_SRL:  w_aluOut = bus.in2 >> w_shamt;
            ALU_SRA:  w_aluOut = $unsigned($signed(bus.in2) >>> w_shamt);
            ALU_MFLO: w_aluOut = w_lo;
            ALU_MFHI: w_aluOut = w_hi;
            ALU_DIV:  w_aluOut = w_lo;
            ALU_MUL:  w_aluOut = w_lo;
            default:  w_aluOut = '0;
        endcase
    end

    // Branch-taken flag evaluated on the ALU result
    always_comb begin
        w_zero = 1'b0;
        case (bus.OpCode)
            OP_BEQ:  w_zero = (w_aluOut == '0);
            OP_BNE:  w_zero = (w_aluOut != '0);
            OP_BLEZ: w_zero = ($signed(w_aluOut) <= 0);
            OP_BGTZ: w_zero = ($signed(w_aluOut) > 0);
            OP_BLTZ: w_zero = w_aluOut[WIDTH-1];
            default: w_zero = 1'b0;
        endcase
    end

    assign w_start = bus.op_valid && isMulDiv(bus.ALUCtl) &&
                     (w_state == ST_IDLE) && !bus.flush;

    muldiv_iter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_muldiv (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_flush (bus.flush),
        .i_isDiv (bus.ALUCtl == ALU_DIV),
        .i_sign  (bus.Sign),
        .i_a     (bus.in1),
        .i_b     (bus.in2),
        .o_hi    (w_hi),
        .o_lo    (w_lo),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_state (w_state)
    );

    assign bus.out     = w_aluOut;
    assign bus.zero    = w_zero;
    assign bus.hi      = w_hi;
    assign bus.lo      = w_lo;
    assign bus.md_busy = w_busy;
    assign bus.md_done = w_done;
    assign bus.stall   = w_busy ||
                         (bus.op_valid && usesHiLo(bus.ALUCtl) && (w_state != ST_IDLE));

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: self-checking bench for alu_muldiv. Expected results come
// from a behavioural model, are queued when stimulus is driven and are
// popped when the DUT presents the matching output.
module tb_alu_muldiv;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk;
    logic reset;
    int   errorCount = 0;
    int   checkCount = 0;
    logic [W-1:0] expVal[$];
    logic [W-1:0] mHi;
    logic [W-1:0] mLo;

    alu_muldiv_if #(.WIDTH(W)) bus();

    alu_muldiv #(.WIDTH(W), .SHW(5), .CW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic popCheck(input string tag, input logic [W-1:0] actual);
        logic [W-1:0] e;
        if (expVal.size() == 0) begin
            checkOutput({tag, "_sbEmpty"}, 64'(expVal.size()), 64'd1);
        end else begin
            e = expVal.pop_front();
            checkOutput(tag, actual, e);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] ctl,
                                 input logic [5:0] opc, input logic sgn,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op_valid = valid;
        bus.ALUCtl   = ctl;
        bus.OpCode   = opc;
        bus.Sign     = sgn;
        bus.in1      = a;
        bus.in2      = b;
    endtask

    function automatic logic [W-1:0] aluModel(input logic [4:0] ctl, input logic sgn,
                                              input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] hv, input logic [W-1:0] lv);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (ctl)
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLT:  return sgn ? W'(sa < sb) : W'(a < b);
            ALU_NOR:  return ~(a | b);
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return b << a[4:0];
            ALU_SRL:  return b >> a[4:0];
            ALU_SRA:  return W'(sb >>> a[4:0]);
            ALU_MFLO, ALU_DIV, ALU_MUL: return lv;
            ALU_MFHI: return hv;
            default:  return '0;
        endcase
    endfunction

    function automatic logic zeroModel(input logic [5:0] opc, input logic [W-1:0] v);
        int sv;
        sv = v;
        case (opc)
            OP_BEQ:  return v == 0;
            OP_BNE:  return v != 0;
            OP_BLEZ: return sv <= 0;
            OP_BGTZ: return sv > 0;
            OP_BLTZ: return sv < 0;
            default: return 1'b0;
        endcase
    endfunction

    // Returns {hi, lo}
    function automatic logic [63:0] mdModel(input logic isMul, input logic sgn,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa64;
        longint sb64;
        int     sa;
        int     sb;
        int     q;
        int     r;
        sa = a;
        sb = b;
        if (isMul) begin
            if (sgn) begin
                sa64 = sa;
                sb64 = sb;
                return 64'(sa64 * sb64);
            end
            return {32'd0, a} * {32'd0, b};
        end
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {32'(r), 32'(q)};
        end
        return {a % b, a / b};
    endfunction

    // Issue one MUL/DIV, check timing, then pop HI/LO from the scoreboard
    task automatic runMd(input logic isMul, input logic sgn,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] r;
        int busyCycles;
        int doneAt;
        busyCycles = 0;
        doneAt = 0;
        r = mdModel(isMul, sgn, a, b);
        expVal.push_back(r[63:32]);
        expVal.push_back(r[31:0]);
        applyStimulus(1'b1, isMul ? ALU_MUL : ALU_DIV, 6'd0, sgn, a, b);
        #1 checkOutput("mdIssueOut", bus.out, mLo);
        mHi = r[63:32];
        mLo = r[31:0];
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        for (int n = 0; n < 200 && bus.md_busy; n++) begin
            busyCycles++;
            if (bus.md_done) doneAt = busyCycles;
            @(posedge clk); #1;
        end
        checkOutput("busyCycles", 64'(busyCycles), 64'(W + 1));
        checkOutput("doneCycle", 64'(doneAt), 64'(W + 1));
        popCheck("hi", bus.hi);
        popCheck("lo", bus.lo);
    endtask

    initial begin
        logic [4:0]   ctls[14];
        logic [5:0]   opcs[6];
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e;
        logic [5:0]   opc;
        logic         sgn;
        logic [63:0]  r;
        int           cnt;

        ctls = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_XOR,
                 ALU_SLL, ALU_SRL, ALU_SRA, ALU_MFLO, ALU_MFHI, 5'b00011, 5'b10101};
        opcs = '{OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, 6'b000000};
        mHi = '0;
        mLo = '0;

        reset = 1'b1;
        bus.flush = 1'b0;
        applyStimulus(1'b0, ALU_AND, 6'd0, 1'b0, '0, '0);
        #12;
        checkOutput("rstHi", bus.hi, 0);
        checkOutput("rstLo", bus.lo, 0);
        checkOutput("rstBusy", bus.md_busy, 0);
        checkOutput("rstDone", bus.md_done, 0);
        checkOutput("rstStall", bus.stall, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Overflowing ADD and two branch conditions on the result
        applyStimulus(1'b1, ALU_ADD, OP_BLTZ, 1'b1, 32'h7FFF_FFFF, 32'h1);
        #1 checkOutput("addOvfOut", bus.out, 32'h8000_0000);
        checkOutput("bltzZero", bus.zero, 1);
        bus.OpCode = OP_BGTZ;
        #1 checkOutput("bgtzZero", bus.zero, 0);

        // Combinational operations over random and boundary operands
        for (int i = 0; i < 14; i++) begin
            for (int j = 0; j < 3; j++) begin
                a = $urandom;
                b = $urandom;
                if (j == 0) begin a = 32'h0000_001F; b = 32'h8000_0000; end
                if (j == 1) begin a = b; end
                sgn = 1'($urandom_range(0, 1));
                opc = opcs[$urandom_range(0, 5)];
                applyStimulus(1'b1, ctls[i], opc, sgn, a, b);
                e = aluModel(ctls[i], sgn, a, b, mHi, mLo);
                expVal.push_back(e);
                #1 popCheck("aluOut", bus.out);
                checkOutput("aluZero", bus.zero, zeroModel(opc, e));
            end
        end
        applyStimulus(1'b0, ALU_AND, 6'd0, 1'b0, '0, '0);
        @(posedge clk); #1;

        // Multiply and divide results including corner cases
        runMd(1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5);
        applyStimulus(1'b1, ALU_MFLO, 6'd0, 1'b0, '0, '0);
        #1 checkOutput("mfloOut", bus.out, 32'hFFFF_FFF1);
        runMd(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runMd(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000);
        runMd(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        runMd(1'b0, 1'b1, 32'd5, 32'd0);
        runMd(1'b0, 1'b0, 32'hFFFF_FFF0, 32'd0);
        runMd(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        runMd(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
        runMd(1'b0, 1'b0, $urandom, $urandom_range(1, 1000));

        // MFHI right behind a MUL is held until the result lands
        r = mdModel(1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        expVal.push_back(r[63:32]);
        applyStimulus(1'b1, ALU_MUL, 6'd0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        @(posedge clk); #1;
        applyStimulus(1'b1, ALU_MFHI, 6'd0, 1'b0, '0, '0);
        cnt = 0;
        for (int n = 0; n < 200 && bus.stall; n++) begin
            cnt++;
            @(posedge clk); #1;
        end
        checkOutput("mfhiStallCycles", 64'(cnt), 64'(W + 1));
        popCheck("mfhiOut", bus.out);
        checkOutput("mfhiLo", bus.lo, r[31:0]);
        mHi = r[63:32];
        mLo = r[31:0];
        @(posedge clk); #1;
        checkOutput("mfhiNoRestart", bus.md_busy, 0);
        applyStimulus(1'b0, ALU_AND, 6'd0, 1'b0, '0, '0);

        // Preload HI/LO with 0x11/0x22, then flush a DIV in its tenth RUN cycle
        runMd(1'b0, 1'b0, 32'h451, 32'h20);
        applyStimulus(1'b1, ALU_DIV, 6'd0, 1'b0, 32'd100, 32'd7);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        #1 checkOutput("flushRunDone", bus.md_done, 0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        checkOutput("flushBusy", bus.md_busy, 0);
        checkOutput("flushHi", bus.hi, 32'h11);
        checkOutput("flushLo", bus.lo, 32'h22);
        cnt = 0;
        repeat (40) begin
            if (bus.md_done) cnt++;
            @(posedge clk); #1;
        end
        checkOutput("flushNoDone", 64'(cnt), 0);

        // Flush and a new MUL in the same cycle: nothing starts
        applyStimulus(1'b1, ALU_MUL, 6'd0, 1'b0, 32'd3, 32'd4);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.op_valid = 1'b0;
        checkOutput("flushWinsBusy", bus.md_busy, 0);

        // Flush during FIX suppresses done and the HI/LO write
        applyStimulus(1'b1, ALU_MUL, 6'd0, 1'b0, 32'd3, 32'd4);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        cnt = 0;
        for (int n = 0; n < 200 && !bus.md_done; n++) begin
            cnt++;
            @(posedge clk); #1;
        end
        checkOutput("fixReachCycles", 64'(cnt), 64'(W));
        bus.flush = 1'b1;
        #1 checkOutput("fixFlushDone", bus.md_done, 0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        checkOutput("fixFlushBusy", bus.md_busy, 0);
        checkOutput("fixFlushHi", bus.hi, 32'h11);
        checkOutput("fixFlushLo", bus.lo, 32'h22);

        // Asynchronous reset in the middle of RUN
        applyStimulus(1'b1, ALU_DIV, 6'd0, 1'b0, 32'd100, 32'd7);
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #1 reset = 1'b1;
        #1;
        checkOutput("midRstHi", bus.hi, 0);
        checkOutput("midRstLo", bus.lo, 0);
        checkOutput("midRstBusy", bus.md_busy, 0);
        checkOutput("midRstDone", bus.md_done, 0);
        checkOutput("midRstStall", bus.stall, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
